// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// the interrupt ExcCode and the default processor ID.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IM_HI = 15;
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [31:0] PRID_DEFAULT = 32'h1999_0101;

endpackage

// File: rtl/cp0_intc.sv
// Minimal MIPS-style CP0: SR, Cause, EPC and PRId plus the six-line
// hardware interrupt request logic with single-level (EXL) masking.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = PRID_DEFAULT,
  parameter logic [29:0] EPC_RST = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  output logic [31:0] DOut,
  input  logic [4:0]  wr_addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  input  logic [31:2] PC,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:2] EPC
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:2] epc;

  assign IntReq = (|(HWInt & im)) & ie & ~exl;
  assign EPC    = epc;

  // A taken interrupt overrides both eret and any same-edge mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= EPC_RST;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        epc      <= PC;
        exl      <= 1'b1;
        exc_code <= EXC_INT;
      end else begin
        if (EXLClr) exl <= 1'b0;
        if (WE && wr_addr == REG_SR) begin
          im  <= DIn[SR_IM_HI:SR_IM_LO];
          exl <= DIn[SR_EXL];
          ie  <= DIn[SR_IE];
        end
        if (WE && wr_addr == REG_EPC) epc <= DIn[31:2];
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (rd_addr)
      REG_SR: begin
        DOut[SR_IM_HI:SR_IM_LO] = im;
        DOut[SR_EXL]            = exl;
        DOut[SR_IE]             = ie;
      end
      REG_CAUSE: begin
        DOut[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        DOut[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
      end
      REG_EPC:  DOut = {epc, 2'b00};
      REG_PRID: DOut = PRID;
      default:  DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed self-checking bench for cp0_intc: reset values, interrupt
// entry, EXL masking, eret, IP lag and mtc0/interrupt priority.
module tb_cp0_intc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [31:0] DOut;
  logic [4:0]  wr_addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:2] PC;
  logic [7:2]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:2] EPC;

  int test_count = 0;
  int fail_count = 0;

  cp0_intc dut (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr),
    .DOut    (DOut),
    .wr_addr (wr_addr),
    .WE      (WE),
    .DIn     (DIn),
    .PC      (PC),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPC     (EPC)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs; called just after a falling edge.
  task automatic applyStimulus(input logic we, input logic [4:0] waddr,
                               input logic [31:0] din, input logic [5:0] hw,
                               input logic [29:0] pc, input logic eret);
    WE      = we;
    wr_addr = waddr;
    DIn     = din;
    HWInt   = hw;
    PC      = pc;
    EXLClr  = eret;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] addr,
                           input logic [31:0] expected);
    rd_addr = addr;
    #1;
    checkOutput(tag, DOut, expected);
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b0, 30'h0, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("reset_intreq", {31'b0, IntReq}, 32'h0);
    readCheck("reset_dout_epc", 5'd14, 32'h0000_3000);
    reset = 1'b0;

    readCheck("rst_sr",    5'd12, 32'h0);
    readCheck("rst_cause", 5'd13, 32'h0);
    readCheck("rst_epc",   5'd14, 32'h0000_3000);
    readCheck("rst_prid",  5'd15, 32'h1999_0101);
    readCheck("unmapped",  5'd5,  32'h0);
    checkOutput("rst_epc_port", {EPC, 2'b00}, 32'h0000_3000);

    // Writes to Cause and PRId are ignored.
    applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 6'b0, 30'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd15, 32'hFFFF_FFFF, 6'b0, 30'h0, 1'b0);
    tick();
    readCheck("cause_wr_ignored", 5'd13, 32'h0);
    readCheck("prid_wr_ignored",  5'd15, 32'h1999_0101);

    // Enable IM[2]/IE with the timer line up; no bypass in the write cycle.
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 6'b000001, 30'h0000_0C10, 1'b0);
    #1;
    checkOutput("pre_write_intreq", {31'b0, IntReq}, 32'h0);
    readCheck("no_bypass_sr", 5'd12, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000001, 30'h0000_0C10, 1'b0);
    #1;
    checkOutput("intreq_asserted", {31'b0, IntReq}, 32'h1);
    tick();
    #1;
    checkOutput("intreq_after_take", {31'b0, IntReq}, 32'h0);
    readCheck("sr_exl_set",    5'd12, 32'h0000_0403);
    readCheck("epc_loaded",    5'd14, 32'h0000_3040);
    readCheck("cause_on_take", 5'd13, 32'h0000_0400);

    // EXL masks every line; eret re-arms the pending request.
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b111111, 30'h0000_0C10, 1'b0);
    tick();
    #1;
    checkOutput("exl_masks", {31'b0, IntReq}, 32'h0);
    readCheck("cause_all_ip", 5'd13, 32'h0000_FC00);
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b111111, 30'h0000_0C10, 1'b1);
    #1;
    checkOutput("eret_cycle", {31'b0, IntReq}, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b111111, 30'h0000_0C10, 1'b0);
    #1;
    checkOutput("after_eret", {31'b0, IntReq}, 32'h1);
    tick();

    // IM mismatch: IP shows the line one cycle late but nothing is requested.
    applyStimulus(1'b1, 5'd12, 32'h0000_0801, 6'b000000, 30'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000001, 30'h0, 1'b0);
    #1;
    checkOutput("im_mismatch", {31'b0, IntReq}, 32'h0);
    readCheck("ip_lag", 5'd13, 32'h0);
    tick();
    readCheck("ip_after_lag", 5'd13, 32'h0000_0400);
    checkOutput("im_mismatch2", {31'b0, IntReq}, 32'h0);

    // Same-edge EPC write is discarded when an interrupt is taken.
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 6'b000001, 30'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd14, 32'h0000_4000, 6'b000001, 30'h0000_0D00, 1'b0);
    #1;
    checkOutput("intreq_collide", {31'b0, IntReq}, 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000001, 30'h0000_0D00, 1'b0);
    readCheck("epc_hw_wins", 5'd14, 32'h0000_3400);
    readCheck("sr_after_collide", 5'd12, 32'h0000_0403);

    // Same-edge SR write is discarded too (interrupt taken again after eret).
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000001, 30'h0000_0D00, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd12, 32'h0000_0000, 6'b000001, 30'h0000_0D04, 1'b0);
    #1;
    checkOutput("intreq_sr_collide", {31'b0, IntReq}, 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000001, 30'h0, 1'b0);
    readCheck("sr_hw_wins", 5'd12, 32'h0000_0403);
    readCheck("epc_second", 5'd14, 32'h0000_3410);

    // Reset mid-handler clears EXL and restores everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readCheck("midreset_sr",  5'd12, 32'h0);
    readCheck("midreset_epc", 5'd14, 32'h0000_3000);

    // Timer line drops before IE is set: request is lost, IP clears a cycle later.
    applyStimulus(1'b1, 5'd12, 32'h0000_0400, 6'b000001, 30'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 6'b000000, 30'h0, 1'b0);
    #1;
    checkOutput("timer_ie0", {31'b0, IntReq}, 32'h0);
    readCheck("ip_before_drop", 5'd13, 32'h0000_0400);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 6'b000000, 30'h0, 1'b0);
    readCheck("ip_after_drop", 5'd13, 32'h0);
    readCheck("sr_ie_set", 5'd12, 32'h0000_0401);
    checkOutput("timer_lost", {31'b0, IntReq}, 32'h0);
    tick();
    #1;
    checkOutput("timer_lost2", {31'b0, IntReq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
